// File: rtl/pfclk_pkg.sv
// Shared constants, state type and command-word helper for the PF clock link TX word generator.
package pfclk_pkg;

  localparam logic [19:0] PFCLK_IDLE_PATTERN = 20'h07C1F;
  localparam logic [19:0] PFCLK_SYNC_PATTERN = 20'h003FF;
  localparam logic [3:0]  CMD_HDR            = 4'b1010;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    ALIGN     = 2'd1,
    RUN       = 2'd2
  } pfclk_state_e;

  // Header nibble, then the byte and its complement so the receiver can self-check it.
  function automatic logic [19:0] pfclk_cmd_word(input logic [7:0] cmd_byte);
    return {CMD_HDR, cmd_byte, ~cmd_byte};
  endfunction

endpackage

// File: rtl/pfclk_sync_bit.sv
// Two-flop synchronizer for a single asynchronous level; clears to 0 on reset.
module pfclk_sync_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pfclk_txword_gen.sv
// Per-cycle 20-bit TX word generator for the PF clock link: idle pattern, orbit sync marker,
// optional fast-control command injection (enabled by defining PFCLK_TXGEN_CMD_EN).
module pfclk_txword_gen
  import pfclk_pkg::*;
#(
  parameter logic [19:0] IDLE_PATTERN = PFCLK_IDLE_PATTERN,
  parameter logic [19:0] SYNC_PATTERN = PFCLK_SYNC_PATTERN,
  parameter int          ORBIT_LEN    = 3564,
  parameter int          LOCK_WAIT    = 1024
) (
  input  logic        clk_link,
  input  logic        soft_reset_n,
  input  logic        pll_lock_in,
  input  logic        tx_reset_done,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_data,
  output logic        cmd_ready,
  output logic [19:0] txdata,
  output logic        link_up,
  output logic        sync_strobe,
  output logic [11:0] bx,
  output logic [15:0] orbit_count
);

  localparam logic [11:0] BX_LAST   = 12'(ORBIT_LEN - 1);
  localparam logic [15:0] LOCK_LAST = 16'(LOCK_WAIT - 1);

  logic pll_lock_s;
  logic tx_reset_done_s;
  logic lock_ok;
  logic cmd_accept;

  pfclk_state_e state_q, state_d;
  logic [15:0]  stable_cnt_q, stable_cnt_d;
  logic [11:0]  bx_q, bx_d;
  logic [15:0]  orbit_count_q, orbit_count_d;
  logic [19:0]  txdata_q, txdata_d;
  logic         sync_strobe_q, sync_strobe_d;
  logic         link_up_q, link_up_d;
  logic         cmd_ready_q, cmd_ready_d;

  pfclk_sync_bit u_sync_pll (
    .clk   (clk_link),
    .rst_n (soft_reset_n),
    .d     (pll_lock_in),
    .q     (pll_lock_s)
  );

  pfclk_sync_bit u_sync_txrst (
    .clk   (clk_link),
    .rst_n (soft_reset_n),
    .d     (tx_reset_done),
    .q     (tx_reset_done_s)
  );

  assign lock_ok = pll_lock_s & tx_reset_done_s;

`ifdef PFCLK_TXGEN_CMD_EN
  assign cmd_accept = cmd_valid & cmd_ready_q;
`else
  logic unused_cmd;
  assign unused_cmd = ^{cmd_valid, cmd_data};
  assign cmd_accept = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    stable_cnt_d  = stable_cnt_q;
    bx_d          = bx_q;
    orbit_count_d = orbit_count_q;
    txdata_d      = IDLE_PATTERN;
    sync_strobe_d = 1'b0;
    link_up_d     = 1'b0;

    if (!lock_ok) begin
      // Lock loss overrides every state; any command accepted this cycle is dropped.
      state_d      = WAIT_LOCK;
      stable_cnt_d = '0;
      bx_d         = '0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          if (stable_cnt_q == LOCK_LAST) begin
            state_d      = ALIGN;
            stable_cnt_d = '0;
          end else begin
            stable_cnt_d = stable_cnt_q + 16'd1;
          end
        end
        ALIGN: begin
          state_d       = RUN;
          bx_d          = '0;
          orbit_count_d = '0;
          txdata_d      = SYNC_PATTERN;
          sync_strobe_d = 1'b1;
          link_up_d     = 1'b1;
        end
        RUN: begin
          link_up_d = 1'b1;
          if (bx_q == BX_LAST) begin
            bx_d          = '0;
            orbit_count_d = orbit_count_q + 16'd1;
            txdata_d      = SYNC_PATTERN;
            sync_strobe_d = 1'b1;
          end else begin
            bx_d = bx_q + 12'd1;
            if (cmd_accept) begin
              txdata_d = pfclk_cmd_word(cmd_data);
            end
          end
        end
        default: begin
          state_d = WAIT_LOCK;
        end
      endcase
    end

    // Ready is registered against the next slot, so it is never high ahead of the sync slot.
`ifdef PFCLK_TXGEN_CMD_EN
    cmd_ready_d = (state_d == RUN) && (bx_d != BX_LAST);
`else
    cmd_ready_d = 1'b0;
`endif
  end

  always_ff @(posedge clk_link or negedge soft_reset_n) begin
    if (!soft_reset_n) begin
      state_q       <= WAIT_LOCK;
      stable_cnt_q  <= '0;
      bx_q          <= '0;
      orbit_count_q <= '0;
      txdata_q      <= IDLE_PATTERN;
      sync_strobe_q <= 1'b0;
      link_up_q     <= 1'b0;
      cmd_ready_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      stable_cnt_q  <= stable_cnt_d;
      bx_q          <= bx_d;
      orbit_count_q <= orbit_count_d;
      txdata_q      <= txdata_d;
      sync_strobe_q <= sync_strobe_d;
      link_up_q     <= link_up_d;
      cmd_ready_q   <= cmd_ready_d;
    end
  end

  assign txdata      = txdata_q;
  assign link_up     = link_up_q;
  assign sync_strobe = sync_strobe_q;
  assign bx          = bx_q;
  assign orbit_count = orbit_count_q;
  assign cmd_ready   = cmd_ready_q;

endmodule
